// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window fetch controller.
//   pixel_t       : one 8-bit grey pixel
//   window_t      : 3x3 neighbourhood, p0 (top-left) in bits [7:0], row-major
//   fetch_state_t : controller states
//   addr_phase_t  : selects source (read) or destination (write) addressing
package sobel_pkg;
  localparam int WORD_BYTES = 4;

  typedef logic [7:0] pixel_t;
  typedef pixel_t [8:0] window_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WIN_OUT,
    RES_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } fetch_state_t;

  typedef enum logic {
    PH_READ,
    PH_WRITE
  } addr_phase_t;
endpackage

// File: rtl/sobel_win_addr_gen.sv
// Combinational byte-address generator.
//   x, y  : centre pixel of the current window
//   k     : tap index 0..8 within the 3x3 window (row-major)
//   phase : PH_READ -> source tap address, PH_WRITE -> destination centre address
//   addr  : 32-bit byte address, one pixel per 32-bit word
module sobel_win_addr_gen
  import sobel_pkg::*;
#(
  parameter int          IMG_W    = 16,
  parameter int          XW       = 4,
  parameter int          YW       = 4,
  parameter logic [31:0] SRC_BASE = 32'h0000_0000,
  parameter logic [31:0] DST_BASE = 32'h0001_0000
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [3:0]    k,
  input  addr_phase_t   phase,
  output logic [31:0]   addr
);

  logic [1:0]  dx;
  logic [1:0]  dy;
  logic [31:0] row;
  logic [31:0] col;
  logic [31:0] base;

  always_comb begin
    dy = 2'(k / 4'd3);
    dx = 2'(k % 4'd3);
    if (phase == PH_READ) begin
      // Taps span centre-1 .. centre+1 in both directions.
      row  = 32'(y) + 32'(dy) - 32'd1;
      col  = 32'(x) + 32'(dx) - 32'd1;
      base = SRC_BASE;
    end else begin
      row  = 32'(y);
      col  = 32'(x);
      base = DST_BASE;
    end
    addr = base + 32'(WORD_BYTES) * (row * 32'(IMG_W) + col);
  end

endmodule

// File: rtl/sobel_window_fetch.sv
// Sobel window fetch controller: reads the 3x3 neighbourhood of every
// interior pixel through the Avalon master, hands the window to the Sobel
// core, and writes the returned magnitude to the destination image.
//   clk, n_rst              : clock / async active-low reset
//   start, busy, done       : frame control
//   readen, writen, inaddr,
//   wdata, dataready,
//   readdata                : Avalon master request/response
//   win_valid, win_ready,
//   window                  : window handshake to the Sobel core
//   res_valid, res_data     : magnitude from the Sobel core
//
// state    | meaning
// IDLE     | waiting for start
// RD_REQ   | one-cycle read request for tap k
// RD_WAIT  | waiting for dataready, capture tap k
// WIN_OUT  | window offered to Sobel core
// RES_WAIT | waiting for Sobel magnitude
// WR_REQ   | one-cycle write request for the centre pixel
// WR_WAIT  | hold address/data for the master write phase
// DONE     | one-cycle done pulse
module sobel_window_fetch
  import sobel_pkg::*;
#(
  parameter int          IMG_W    = 16,
  parameter int          IMG_H    = 16,
  parameter logic [31:0] SRC_BASE = 32'h0000_0000,
  parameter logic [31:0] DST_BASE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        readen,
  output logic        writen,
  output logic [31:0] inaddr,
  output logic [31:0] wdata,
  input  logic        dataready,
  input  logic [31:0] readdata,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [71:0] window,
  input  logic        res_valid,
  input  logic [7:0]  res_data
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 2);

  fetch_state_t  state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [3:0]    k_q, k_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          readen_q, readen_d;
  logic          writen_q, writen_d;
  logic [31:0]   inaddr_q, inaddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          win_valid_q, win_valid_d;
  window_t       window_q, window_d;
  logic [31:0]   addr;
  addr_phase_t   phase;
  logic          unused_rd_hi;

  // Only the low byte of each SRAM word carries a pixel.
  assign unused_rd_hi = ^readdata[31:8];

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    wcnt_d   = wcnt_q;
    busy_d   = busy_q;
    wdata_d  = wdata_q;
    window_d = window_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_REQ;
          busy_d  = 1'b1;
          x_d     = XW'(1);
          y_d     = YW'(1);
          k_d     = 4'd0;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (dataready) begin
          window_d[k_q] = readdata[7:0];
          if (k_q < 4'd8) begin
            k_d     = k_q + 4'd1;
            state_d = RD_REQ;
          end else begin
            state_d = WIN_OUT;
          end
        end
      end
      WIN_OUT: begin
        if (win_valid_q && win_ready) state_d = RES_WAIT;
      end
      RES_WAIT: begin
        if (res_valid) begin
          wdata_d = {24'h0, res_data};
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        state_d = WR_WAIT;
        wcnt_d  = 2'd2;
      end
      WR_WAIT: begin
        wcnt_d = wcnt_q - 2'd1;
        if (wcnt_q == 2'd1) begin
          if (x_q < X_LAST) begin
            x_d = x_q + 1'b1;
          end else begin
            x_d = XW'(1);
            y_d = y_q + 1'b1;
          end
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d = DONE;
          end else begin
            k_d     = 4'd0;
            state_d = RD_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    readen_d    = (state_d == RD_REQ);
    writen_d    = (state_d == WR_REQ);
    win_valid_d = (state_d == WIN_OUT);
    done_d      = (state_d == DONE);
    if (state_d == DONE) busy_d = 1'b0;
  end

  // Address is generated from the next-cycle coordinates so it lines up with
  // the registered request strobe.
  assign phase = (state_d == WR_REQ) ? PH_WRITE : PH_READ;

  sobel_win_addr_gen #(
    .IMG_W   (IMG_W),
    .XW      (XW),
    .YW      (YW),
    .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE)
  ) u_addr_gen (
    .x    (x_d),
    .y    (y_d),
    .k    (k_d),
    .phase(phase),
    .addr (addr)
  );

  always_comb begin
    inaddr_d = inaddr_q;
    if (state_d == RD_REQ || state_d == WR_REQ) inaddr_d = addr;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      x_q         <= XW'(1);
      y_q         <= YW'(1);
      k_q         <= 4'd0;
      wcnt_q      <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      readen_q    <= 1'b0;
      writen_q    <= 1'b0;
      inaddr_q    <= 32'h0;
      wdata_q     <= 32'h0;
      win_valid_q <= 1'b0;
      window_q    <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      k_q         <= k_d;
      wcnt_q      <= wcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      readen_q    <= readen_d;
      writen_q    <= writen_d;
      inaddr_q    <= inaddr_d;
      wdata_q     <= wdata_d;
      win_valid_q <= win_valid_d;
      window_q    <= window_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign readen    = readen_q;
  assign writen    = writen_q;
  assign inaddr    = inaddr_q;
  assign wdata     = wdata_q;
  assign win_valid = win_valid_q;
  assign window    = window_q;

endmodule

// File: tb/tb_sobel_window_fetch.sv
// Self-checking bench for sobel_window_fetch: behavioural Avalon master and
// Sobel core, scoreboard queues filled when a frame is launched.
module tb_sobel_window_fetch;
  localparam int          W   = 16;
  localparam int          H   = 16;
  localparam logic [31:0] SRC = 32'h0000_0000;
  localparam logic [31:0] DST = 32'h0001_0000;
  localparam int          NPIX = (W - 2) * (H - 2);

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, readen, writen, win_valid;
  logic [31:0] inaddr, wdata;
  logic        dataready, win_ready, res_valid;
  logic [31:0] readdata;
  logic [71:0] window;
  logic [7:0]  res_data;

  logic        m_dr = 1'b0, stray_dr = 1'b0, s_rv = 1'b0, stray_rv = 1'b0, ready_en = 1'b1;
  logic [31:0] m_rdata = 32'h0, m_addr = 32'h0;
  logic [7:0]  s_data = 8'h0;
  int          m_tmr = 0, s_tmr = 0, wh_cnt = 0;
  logic [31:0] wh_addr, wh_data;
  logic        readen_prev = 1'b0, writen_prev = 1'b0;

  assign dataready = m_dr | stray_dr;
  assign readdata  = m_dr ? m_rdata : 32'hA5A5_A5A5;
  assign win_ready = ready_en;
  assign res_valid = s_rv | stray_rv;
  assign res_data  = s_rv ? s_data : 8'hEE;

  sobel_window_fetch #(
    .IMG_W(W), .IMG_H(H), .SRC_BASE(SRC), .DST_BASE(DST)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .busy(busy), .done(done),
    .readen(readen), .writen(writen), .inaddr(inaddr), .wdata(wdata),
    .dataready(dataready), .readdata(readdata), .win_valid(win_valid),
    .win_ready(win_ready), .window(window), .res_valid(res_valid),
    .res_data(res_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_rd[$];
  logic [71:0] exp_win[$];
  logic [31:0] exp_wr_addr[$];
  logic [31:0] exp_wr_data[$];
  int          rd_count = 0, wr_count = 0, done_count = 0;
  int          last_wr_cyc = -100, last_dr_cyc = -100;
  bit          prev_wr = 1'b1;
  logic [31:0] last_wr_addr = 32'h0;

  function automatic logic [7:0] pix(input logic [31:0] a);
    return 8'((a >> 2) * 37 + 11);
  endfunction

  function automatic logic [7:0] sob(input logic [71:0] w);
    int s = 0;
    for (int i = 0; i < 9; i++) s += (i + 1) * int'(w[i*8 +: 8]);
    return 8'(s ^ (s >> 8));
  endfunction

  task automatic push_frame();
    logic [71:0] w;
    logic [31:0] a;
    exp_rd.delete(); exp_win.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
    rd_count = 0; wr_count = 0; done_count = 0;
    prev_wr = 1'b1; last_wr_cyc = -100;
    for (int y = 1; y <= H - 2; y++) begin
      for (int x = 1; x <= W - 2; x++) begin
        for (int k = 0; k < 9; k++) begin
          a = SRC + 32'(4 * ((y + k / 3 - 1) * W + (x + k % 3 - 1)));
          exp_rd.push_back(a);
          w[k*8 +: 8] = pix(a);
        end
        exp_win.push_back(w);
        exp_wr_addr.push_back(DST + 32'(4 * (y * W + x)));
        exp_wr_data.push_back({24'h0, sob(w)});
      end
    end
  endtask

  // Behavioural master, Sobel core and protocol/scoreboard monitor.
  always @(negedge clk) begin
    logic [31:0] rnd;
    m_dr = 1'b0;
    s_rv = 1'b0;
    if (!n_rst) begin
      m_tmr = 0; s_tmr = 0; wh_cnt = 0;
      readen_prev = 1'b0; writen_prev = 1'b0;
    end else begin
      if (m_tmr > 0) begin
        n_cmp++;
        if (inaddr !== m_addr) begin
          n_bad++; $display("FAIL rd_addr_hold: got %h expected %h", inaddr, m_addr);
        end
        m_tmr--;
        if (m_tmr == 0) begin
          rnd = $urandom();
          m_dr = 1'b1;
          m_rdata = {rnd[31:8], pix(m_addr)};
          last_dr_cyc = cyc;
        end
      end
      if (s_tmr > 0) begin
        s_tmr--;
        if (s_tmr == 0) s_rv = 1'b1;
      end
      if (wh_cnt > 0) begin
        n_cmp++;
        if (inaddr !== wh_addr || wdata !== wh_data) begin
          n_bad++; $display("FAIL wr_hold: got %h/%h expected %h/%h", inaddr, wdata, wh_addr, wh_data);
        end
        wh_cnt--;
      end
      if (readen) begin
        n_cmp++;
        if (exp_rd.size() == 0) begin
          n_bad++; $display("FAIL rd_unexpected: got %h expected none", inaddr);
        end else if (inaddr !== exp_rd[0]) begin
          n_bad++; $display("FAIL rd_addr: got %h expected %h", inaddr, exp_rd[0]);
        end
        if (exp_rd.size() != 0) void'(exp_rd.pop_front());
        n_cmp++;
        if (readen_prev !== 1'b0) begin
          n_bad++; $display("FAIL rd_pulse_width: got 2+ cycles expected 1");
        end
        n_cmp++;
        if (prev_wr ? (cyc - last_wr_cyc < 3) : (cyc != last_dr_cyc + 1)) begin
          n_bad++; $display("FAIL rd_spacing: got cycle %0d expected dr+1=%0d / wr+3=%0d", cyc, last_dr_cyc + 1, last_wr_cyc + 3);
        end
        m_tmr = 3; m_addr = inaddr; rd_count++; prev_wr = 1'b0;
      end
      if (writen) begin
        n_cmp++;
        if (exp_wr_addr.size() == 0) begin
          n_bad++; $display("FAIL wr_unexpected: got %h expected none", inaddr);
        end else if (inaddr !== exp_wr_addr[0] || wdata !== exp_wr_data[0]) begin
          n_bad++; $display("FAIL wr_txn: got %h/%h expected %h/%h", inaddr, wdata, exp_wr_addr[0], exp_wr_data[0]);
        end
        if (exp_wr_addr.size() != 0) begin
          void'(exp_wr_addr.pop_front()); void'(exp_wr_data.pop_front());
        end
        n_cmp++;
        if (writen_prev !== 1'b0 || cyc - last_wr_cyc < 3) begin
          n_bad++; $display("FAIL wr_spacing: got cycle %0d expected >= %0d single pulse", cyc, last_wr_cyc + 3);
        end
        wh_cnt = 2; wh_addr = inaddr; wh_data = wdata;
        last_wr_cyc = cyc; last_wr_addr = inaddr; prev_wr = 1'b1; wr_count++;
      end
      if (readen && writen) begin
        n_cmp++; n_bad++; $display("FAIL rd_wr_overlap: got both 1 expected exclusive");
      end
      if (win_valid && win_ready) begin
        n_cmp++;
        if (exp_win.size() == 0) begin
          n_bad++; $display("FAIL win_unexpected: got %h expected none", window);
        end else if (window !== exp_win[0]) begin
          n_bad++; $display("FAIL window: got %h expected %h", window, exp_win[0]);
        end
        if (exp_win.size() != 0) void'(exp_win.pop_front());
        s_tmr = 2; s_data = sob(window);
      end
      if (done) begin
        done_count++;
        n_cmp++;
        if (busy !== 1'b0 || cyc - last_wr_cyc != 3) begin
          n_bad++; $display("FAIL done_timing: got busy=%b dt=%0d expected busy=0 dt=3", busy, cyc - last_wr_cyc);
        end
      end
      readen_prev = readen;
      writen_prev = writen;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int d0 = done_count;
    int n = 0;
    while (done_count == d0 && n < 30000) begin tick(); n++; end
    ok = (done_count != d0);
  endtask

  task automatic check_frame_end(input string name, input bit ok);
    // Shared end-of-frame wait result; comparisons stay in the callers.
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({busy, done, readen, writen, win_valid} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, readen, writen, win_valid});
    end
    n_cmp++;
    if (inaddr !== 32'h0) begin n_bad++; $display("FAIL reset_inaddr: got %h expected 0", inaddr); end
    n_cmp++;
    if (wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h expected 0", wdata); end
    n_cmp++;
    if (window !== 72'h0) begin n_bad++; $display("FAIL reset_window: got %h expected 0", window); end
    n_rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic frame_counts(input string name);
    n_cmp++;
    if (rd_count != NPIX * 9) begin n_bad++; $display("FAIL %s_reads: got %0d expected %0d", name, rd_count, NPIX * 9); end
    n_cmp++;
    if (wr_count != NPIX) begin n_bad++; $display("FAIL %s_writes: got %0d expected %0d", name, wr_count, NPIX); end
    n_cmp++;
    if (done_count != 1) begin n_bad++; $display("FAIL %s_done_count: got %0d expected 1", name, done_count); end
    n_cmp++;
    if (exp_rd.size() + exp_win.size() + exp_wr_addr.size() != 0) begin
      n_bad++; $display("FAIL %s_leftover: got %0d expected 0", name, exp_rd.size() + exp_win.size() + exp_wr_addr.size());
    end
  endtask

  task automatic test_full_frame();
    bit ok;
    push_frame(); ready_en = 1'b1;
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL start_busy: got %b expected 1", busy); end
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL full_timeout: got no done expected done"); end
    tick(); tick(); tick();
    frame_counts("full");
    n_cmp++;
    if (last_wr_addr !== 32'h0001_03B8) begin n_bad++; $display("FAIL last_wr_addr: got %h expected 000103b8", last_wr_addr); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    push_frame(); ready_en = 1'b1;
    pulse_start();
    while (rd_count < 4 * 9 + 1 && n < 2000) begin tick(); n++; end
    n_cmp++;
    if (rd_count < 37 || readen !== 1'b0) begin
      n_bad++; $display("FAIL midreset_reach: got reads=%0d readen=%b expected 37/0", rd_count, readen);
    end
    n_rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, readen, writen, win_valid} !== 5'b0 || inaddr !== 32'h0 || wdata !== 32'h0 || window !== 72'h0) begin
      n_bad++; $display("FAIL midreset_outputs: got %b/%h/%h/%h expected all 0", {busy, done, readen, writen, win_valid}, inaddr, wdata, window);
    end
    tick(); tick(); tick();
    exp_rd.delete(); exp_win.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || readen !== 1'b0) begin
        n_bad++; $display("FAIL midreset_quiet: got busy=%b done=%b rd=%b expected 0", busy, done, readen);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n = 0;
    logic [71:0] w;
    push_frame(); ready_en = 1'b0;
    pulse_start();
    while (readen !== 1'b1 && n < 20) begin tick(); n++; end
    n_cmp++;
    if (readen !== 1'b1 || inaddr !== SRC) begin n_bad++; $display("FAIL restart_addr: got %b/%h expected 1/%h", readen, inaddr, SRC); end
    n = 0;
    while (win_valid !== 1'b1 && n < 200) begin tick(); n++; end
    n_cmp++;
    if (win_valid !== 1'b1) begin n_bad++; $display("FAIL bp_win_timeout: got 0 expected 1"); end
    w = window;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (win_valid !== 1'b1 || window !== w || readen !== 1'b0 || writen !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold: got v=%b win=%h rd=%b expected v=1 win=%h rd=0", win_valid, window, readen, w);
      end
    end
    ready_en = 1'b1;
    tick();
    n_cmp++;
    if (win_valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept: got %b expected 0", win_valid); end
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_timeout: got no done expected done"); end
    tick(); tick(); tick();
    frame_counts("bp");
  endtask

  task automatic test_start_while_busy();
    bit ok;
    int r0, w0;
    push_frame(); ready_en = 1'b1;
    pulse_start();
    repeat (50) tick();
    pulse_start();
    repeat (300) tick();
    pulse_start();
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL busy_timeout: got no done expected done"); end
    repeat (4) tick();
    frame_counts("busy");
    r0 = rd_count; w0 = wr_count;
    stray_dr = 1'b1; stray_rv = 1'b1;
    tick();
    stray_dr = 1'b0; stray_rv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if ({busy, done, readen, writen, win_valid} !== 5'b0) begin
        n_bad++; $display("FAIL idle_stray: got %b expected 00000", {busy, done, readen, writen, win_valid});
      end
    end
    n_cmp++;
    if (rd_count != r0 || wr_count != w0) begin
      n_bad++; $display("FAIL idle_counts: got %0d/%0d expected %0d/%0d", rd_count, wr_count, r0, w0);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_full_frame();
    test_reset_midframe();
    test_backpressure();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sobel_window_fetch.md
Name: sobel_window_fetch

Overview:
Upstream controller for avalon_master_fsm. It walks the source image in SRAM and issues one 32-bit read per pixel to build each 3x3 neighbourhood. It hands each window to the Sobel compute core, collects the 8-bit magnitude, and issues the write-back to the destination image. It is the sole driver of the master FSM's readen/writen/inaddr/wdata inputs.

Parameters:
IMG_W, 16, image width in pixels (>=3)
IMG_H, 16, image height in pixels (>=3)
SRC_BASE, 32'h0000_0000, byte address of source pixel (0,0); one pixel per 32-bit word, pixel in bits [7:0]
DST_BASE, 32'h0001_0000, byte address of destination pixel (0,0), same layout

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse, begin a frame
busy  out  1  high from the cycle after accepted start until done
done  out  1  1-cycle pulse after last write completes
readen  out  1  read request to master, 1-cycle pulse
writen  out  1  write request to master, 1-cycle pulse
inaddr  out  32  byte address to master, held for whole transaction
wdata  out  32  write data to master, {24'h0, magnitude}
dataready  in  1  master: readdata valid this cycle
readdata  in  32  SRAM read data, sampled only when dataready=1
win_valid  out  1  window valid to Sobel core
win_ready  in  1  Sobel core accepts window
window  out  72  p0..p8 row-major, p0 = top-left in bits [7:0]
res_valid  in  1  Sobel result valid
res_data  in  8  Sobel magnitude

Behaviour:
- Reset: all outputs 0; state IDLE; x=1, y=1, k=0; window regs 0. Reset mid-frame abandons the frame, and no done pulse is issued.
- All outputs are registered.
- States:
  - IDLE: start=1 goes to RD_REQ, sets busy. start while busy is ignored.
  - RD_REQ: readen=1 for exactly one cycle. inaddr = SRC_BASE + 4*((y+dy-1)*IMG_W + (x+dx-1)), where dy=k/3 and dx=k%3. Next state RD_WAIT.
  - RD_WAIT: readen=0, inaddr held. On dataready, window[k] <= readdata[7:0]. If k<8 then k++ and go to RD_REQ; else go to WIN_OUT. dataready outside RD_WAIT is ignored.
  - WIN_OUT: win_valid=1, window held. On win_valid&&win_ready, go to RES_WAIT. Backpressure is unbounded.
  - RES_WAIT: on res_valid, wdata <= {24'h0,res_data} and go to WR_REQ. res_valid in other states is ignored.
  - WR_REQ: writen=1 for one cycle, inaddr = DST_BASE + 4*(y*IMG_W + x). Next state WR_WAIT with wait counter 2.
  - WR_WAIT: hold inaddr and wdata for 2 cycles, matching master WRITE and WRITEDATA, then advance.
  - Advance after WR_WAIT:
    - If x<IMG_W-2: x++.
    - Else x=1 and y++.
    - If the finished pixel was (IMG_W-2, IMG_H-2): go to DONE. Otherwise k=0 and go to RD_REQ.
  - DONE: done=1 for one cycle, busy drops the same cycle, return to IDLE.
- Master timing:
  - Read: readen at cycle t, dataready at t+3, next request earliest t+4.
  - Write: writen at t, next request earliest t+3.
  - readen and writen are never both high.
- Border pixels (x=0, x=IMG_W-1, y=0, y=IMG_H-1) are never written.
- Per frame: (IMG_W-2)*(IMG_H-2) outputs, 9 reads and 1 write each.
- Address arithmetic is 32-bit unsigned. Wrap-around at 2^32 is not detected.
- x and y are $clog2(IMG_W) / $clog2(IMG_H) bits; k is 4 bits.

Decomposition:
- Package sobel_pkg:
  - pixel_t (8-bit)
  - window_t (9 x pixel_t, packed)
  - fetch_state_t enum {IDLE, RD_REQ, RD_WAIT, WIN_OUT, RES_WAIT, WR_REQ, WR_WAIT, DONE}
  - WORD_BYTES=4
- One sub-module: sobel_win_addr_gen, combinational (x, y, k, phase) -> byte address, instantiated once.

Test Plan:
- IMG_W=IMG_H=3, start -> 9 readen pulses with inaddr 0x00,0x04,…,0x20 in order; win_valid with window = readdata bytes 1..9; res_data=0x5A -> one writen, inaddr=0x0001_0010, wdata=0x0000_005A; done 3 cycles later.
- Protocol check with behavioural master -> each readen exactly 1 cycle, inaddr stable until dataready, next readen exactly 1 cycle after dataready; writen spacing >=3 cycles.
- win_ready held 0 for 10 cycles -> win_valid and window stable for all 10; no reads issued; accepted on first ready cycle.
- Default 16x16 -> 1764 reads, 196 writes, last write inaddr 0x0001_0000+4*(14*16+14)=0x0001_03B8, single done pulse.
- n_rst asserted during RD_WAIT of pixel 5 -> all outputs 0 immediately; after release, a new start begins at inaddr 0x00.
- start pulsed while busy -> ignored; read/write counts unchanged; later dataready and res_valid pulses in IDLE cause no outputs.
